// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by uart_tx and the upcoming uart_rx.
//   UART_DATA_W          : width of one UART character
//   uart_data_t          : one UART character
//   ST_IDLE .. ST_STOP   : 3-bit transmitter/receiver frame states
//   PAR_NONE/ODD/EVEN    : parity mode selector values
//   parity_bit()         : parity bit for a character under a given mode
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef logic [UART_DATA_W-1:0] uart_data_t;

    // Frame states, kept as plain constants so legacy code can compare raw values.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARM   = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_PAR   = 3'd4;
    localparam logic [2:0] ST_STOP  = 3'd5;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    // Callers decide whether a parity bit is sent at all.
    function automatic logic parity_bit(input uart_data_t data, input int mode);
        return (mode == PAR_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte handshake between an upstream producer and the UART transmitter.
//   tx_data  : byte to send, sampled only on the accepting edge
//   tx_valid : producer has a byte on tx_data
//   tx_ready : transmitter can accept a byte this cycle
// Modports: master = producer side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_if;
    import uart_pkg::*;

    uart_data_t tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// 8-bit UART transmitter. Accepts a byte over a valid/ready handshake and
// shifts it out LSB-first, one bit per baud_tick: start, 8 data bits,
// optional parity, then 1 or 2 stop bits.
// Parameters:
//   PARITY    : 0 none, 1 odd, 2 even (3 behaves as none)
//   STOP_BITS : 1 or 2 (anything else behaves as 1)
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   baud_tick : one-clk pulse per bit period from the baud prescaler
//   bus       : slave side of the byte handshake (tx_data/tx_valid/tx_ready)
//   tx        : registered serial line, idle high
//   tx_busy   : high whenever a frame is pending or in flight
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      baud_tick,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      tx_busy
);

    localparam logic PAR_EN    = (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
    // Value of the stop counter on the last stop tick.
    localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    logic [2:0] state_q,    state_d;
    uart_data_t shift_q,    shift_d;
    logic       par_q,      par_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       tx_q,       tx_d;

    assign bus.tx_ready = (state_q == ST_IDLE);
    assign tx_busy      = (state_q != ST_IDLE);
    assign tx           = tx_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path can infer a latch.
        state_d    = state_q;
        shift_d    = shift_q;
        par_d      = par_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        tx_d       = tx_q;

        case (state_q)
            ST_IDLE: begin
                // baud_tick is deliberately ignored here: a tick on the accept
                // edge must not start the frame, ARM waits for the next one.
                if (bus.tx_valid) begin
                    shift_d = bus.tx_data;
                    par_d   = parity_bit(bus.tx_data, PARITY);
                    state_d = ST_ARM;
                end
            end

            ST_ARM: begin
                if (baud_tick) begin
                    tx_d       = 1'b0;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    state_d    = ST_START;
                end
            end

            ST_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                    state_d   = ST_DATA;
                end
            end

            ST_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q < 3'd7) begin
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (PAR_EN) begin
                        tx_d    = par_q;
                        state_d = ST_PAR;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end
                end
            end

            ST_PAR: begin
                if (baud_tick) begin
                    tx_d    = 1'b1;
                    state_d = ST_STOP;
                end
            end

            ST_STOP: begin
                // tx is already high; only count stop periods.
                if (baud_tick) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end

            default: begin
                tx_d    = 1'b1;
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its _d value from the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: datapath registers are reset along with control, so an
            // aborted frame leaves no stale byte or parity behind.
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            par_q      <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            tx_q       <= tx_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Three uart_tx lanes with different parity/stop settings share clk, rst_n and
// a baud_tick every TICK_DIV clocks:
//   lane 0: PARITY=0, STOP_BITS=1
//   lane 1: PARITY=2 (even), STOP_BITS=2
//   lane 2: PARITY=1 (odd), STOP_BITS=1
// Accepted bytes are pushed into a per-lane queue; a per-lane monitor samples
// tx once per bit period, rebuilds each frame and compares it against a frame
// built from the byte by the reference model.
// -----------------------------------------------------------------------------
module tb_uart_tx;
    import uart_pkg::*;

    localparam int N_LANES  = 3;
    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic baud_tick;
    logic tick_at_pos = 1'b0;
    int   tick_cnt;

    logic [7:0] data_drv  [N_LANES];
    logic       valid_drv [N_LANES];
    logic       ready_w   [N_LANES];
    logic       tx_w      [N_LANES];
    logic       busy_w    [N_LANES];

    logic [7:0] exp_q [N_LANES][$];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Free-running prescaler stand-in: one-clk tick every TICK_DIV clocks.
    initial begin
        baud_tick = 1'b0;
        tick_cnt  = 0;
        forever begin
            @(negedge clk);
            tick_cnt  = (tick_cnt + 1) % TICK_DIV;
            baud_tick = (tick_cnt == 0);
        end
    end

    // Remembers whether the last rising edge was a tick edge.
    always @(posedge clk) tick_at_pos <= baud_tick;

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int frame_len(input int par, input int stops);
        return 1 + 8 + ((par == PAR_ODD || par == PAR_EVEN) ? 1 : 0) + ((stops == 2) ? 2 : 1);
    endfunction

    // Line levels of one frame, bit 0 = first bit period (start bit).
    function automatic logic [11:0] ref_frame(input logic [7:0] b, input int par, input int stops);
        logic [11:0] f;
        int pos;
        int ones;
        f    = '0;
        pos  = 1;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[pos] = b[i];
            ones   = ones + int'(b[i]);
            pos++;
        end
        if (par == PAR_ODD) begin
            f[pos] = (ones % 2 == 0);
            pos++;
        end else if (par == PAR_EVEN) begin
            f[pos] = (ones % 2 == 1);
            pos++;
        end
        for (int k = 0; k < ((stops == 2) ? 2 : 1); k++) begin
            f[pos] = 1'b1;
            pos++;
        end
        return f;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_frame(input int l, input int par, input int stops, input logic [11:0] got);
        logic [7:0] b;
        check($sformatf("lane%0d_frame_expected", l), (exp_q[l].size() > 0) ? 1 : 0, 1);
        if (exp_q[l].size() > 0) begin
            b = exp_q[l].pop_front();
            check($sformatf("lane%0d_frame_%02h", l, b), got, ref_frame(b, par, stops));
        end
    endtask

    // ---------------- lanes: DUT + monitor ----------------
    for (genvar g = 0; g < N_LANES; g++) begin : lane
        localparam int P    = (g == 0) ? PAR_NONE : (g == 1) ? PAR_EVEN : PAR_ODD;
        localparam int S    = (g == 1) ? 2 : 1;
        localparam int FLEN = 1 + 8 + ((P != PAR_NONE) ? 1 : 0) + S;

        uart_tx_if bus ();
        assign bus.tx_data  = data_drv[g];
        assign bus.tx_valid = valid_drv[g];
        assign ready_w[g]   = bus.tx_ready;

        uart_tx #(.PARITY(P), .STOP_BITS(S)) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .baud_tick(baud_tick),
            .bus      (bus),
            .tx       (tx_w[g]),
            .tx_busy  (busy_w[g])
        );

        logic        in_frame    = 1'b0;
        int          nbits       = 0;
        logic [11:0] got         = '0;
        logic        last_tx     = 1'b1;
        int          glitches    = 0;
        int          since_start = 1000;
        int          last_period = 0;

        always @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                in_frame    = 1'b0;
                nbits       = 0;
                last_tx     = 1'b1;
                since_start = 1000;
            end else begin
                if (!tick_at_pos && (tx_w[g] != last_tx)) glitches++;
                last_tx = tx_w[g];
                if (tick_at_pos) begin
                    since_start++;
                    if (in_frame) begin
                        got[nbits] = tx_w[g];
                        nbits++;
                        if (nbits == FLEN) begin
                            in_frame = 1'b0;
                            check_frame(g, P, S, got);
                        end
                    end else if (tx_w[g] == 1'b0) begin
                        in_frame    = 1'b1;
                        got         = '0;
                        nbits       = 1;
                        last_period = since_start;
                        since_start = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Presents b and holds it until accepted; returns just after the accept edge.
    task automatic send(input int l, input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        valid_drv[l] = 1'b1;
        data_drv[l]  = b;
        while (!ready_w[l] && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("lane%0d_accept_%02h", l, b), ready_w[l], 1);
        if (ready_w[l]) exp_q[l].push_back(b);
        @(posedge clk);
    endtask

    // Drops valid and scrambles data (must not disturb the frame in flight).
    task automatic idle(input int l, input int n);
        @(negedge clk);
        valid_drv[l] = 1'b0;
        data_drv[l]  = 8'($urandom);
        for (int i = 1; i < n; i++) @(negedge clk);
    endtask

    task automatic wait_done(input int l);
        int waited;
        waited = 0;
        @(negedge clk);
        while ((exp_q[l].size() != 0 || busy_w[l]) && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("lane%0d_drained", l), (exp_q[l].size() == 0 && !busy_w[l]) ? 1 : 0, 1);
    endtask

    task automatic wait_tx_fall(input int l);
        int waited;
        waited = 0;
        while (tx_w[l] && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("lane%0d_start_seen", l), tx_w[l], 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int         n;
        logic [7:0] b;

        rst_n = 1'b0;
        for (int l = 0; l < N_LANES; l++) begin
            valid_drv[l] = 1'b0;
            data_drv[l]  = '0;
        end
        repeat (2) @(negedge clk);
        for (int l = 0; l < N_LANES; l++) begin
            check($sformatf("lane%0d_reset_tx", l), tx_w[l], 1);
            check($sformatf("lane%0d_reset_ready", l), ready_w[l], 1);
            check($sformatf("lane%0d_reset_busy", l), busy_w[l], 0);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 0x55 with no parity: busy falls 10 bit periods after the start bit begins.
        send(0, 8'h55);
        idle(0, 1);
        wait_tx_fall(0);
        n = 0;
        while (busy_w[0] && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("lane0_busy_len_55", n, frame_len(PAR_NONE, 1) * TICK_DIV);
        wait_done(0);

        // Parity: 0x07 has three ones -> even parity 1, odd parity 0.
        send(1, 8'h07);
        idle(1, 1);
        wait_done(1);
        check("lane1_even_parity_07", lane[1].got[9], 1);
        send(2, 8'h07);
        idle(2, 1);
        wait_done(2);
        check("lane2_odd_parity_07", lane[2].got[9], 0);

        // Back-to-back with valid held: next start follows the IDLE re-entry tick,
        // so start-to-start is the frame length plus that one tick.
        send(1, 8'hA0);
        send(1, 8'h0F);
        idle(1, 1);
        wait_done(1);
        check("lane1_b2b_period", lane[1].last_period, frame_len(PAR_EVEN, 2) + 1);

        // valid pulsed with 0xFF mid-frame must be ignored.
        send(0, 8'h3A);
        idle(0, 10);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_drv[0] = 1'b1;
            data_drv[0]  = 8'hFF;
            check("lane0_ready_midframe", ready_w[0], 0);
        end
        idle(0, 1);
        wait_done(0);

        // Accept on a tick edge: that tick is not consumed.
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!baud_tick && n < 20);
        repeat (TICK_DIV) @(negedge clk);
        valid_drv[0] = 1'b1;
        data_drv[0]  = 8'h96;
        check("lane0_same_edge_ready", ready_w[0], 1);
        exp_q[0].push_back(8'h96);
        @(posedge clk);
        check("same_edge_tick_aligned", baud_tick, 1);
        idle(0, 1);
        check("lane0_same_edge_ready_drop", ready_w[0], 0);
        check("lane0_same_edge_busy", busy_w[0], 1);
        check("lane0_same_edge_tx_hold", tx_w[0], 1);
        repeat (TICK_DIV - 1) @(negedge clk);
        check("lane0_same_edge_tx_before_tick", tx_w[0], 1);
        @(negedge clk);
        check("lane0_same_edge_tx_start", tx_w[0], 0);
        wait_done(0);

        // Randomized traffic on every lane, mixing gaps and back-to-back bytes.
        for (int l = 0; l < N_LANES; l++) begin
            for (int k = 0; k < 15; k++) begin
                send(l, 8'($urandom));
                if ($urandom_range(0, 3) != 0) idle(l, int'($urandom_range(1, 30)));
            end
            idle(l, 1);
            wait_done(l);
        end

        // Reset during data bit 3, then a clean frame.
        b = 8'hC3;
        send(0, b);
        idle(0, 1);
        wait_tx_fall(0);
        repeat (4 * TICK_DIV + 1) @(negedge clk);
        check("lane0_bit3_before_reset", tx_w[0], b[3]);
        #1 rst_n = 1'b0;
        #1;
        check("lane0_abort_tx", tx_w[0], 1);
        check("lane0_abort_ready", ready_w[0], 1);
        check("lane0_abort_busy", busy_w[0], 0);
        exp_q[0].delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        send(0, 8'h3C);
        idle(0, 1);
        wait_done(0);

        check("lane0_tx_only_on_ticks", lane[0].glitches, 0);
        check("lane1_tx_only_on_ticks", lane[1].glitches, 0);
        check("lane2_tx_only_on_ticks", lane[2].glitches, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
